// File: rtl/fetch_pkg.sv
// Shared types and constants for the picoMIPS fetch stage.
// Provides the fetch state encoding, default widths and the NOP word.
package fetch_pkg;

   localparam int DEF_PSIZE = 6;
   localparam int DEF_ISIZE = 24;
   localparam int OPC_W     = 6;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      EXEC  = 2'd1,
      FLUSH = 2'd2,
      HALT  = 2'd3
   } state_t;

   // All-zero word decodes as the NOP opcode.
   localparam logic [DEF_ISIZE-1:0] NOP_WORD = '0;

endpackage

// File: rtl/fetch_unit.sv
// picoMIPS instruction fetch stage: owns the PC, drives the synchronous
// program ROM and feeds the decoder with run/step control and halt.
//
// Ports:
//   clk, n_reset                 clock, async active-low reset
//   run, step                    free-run level / single-step pulse
//   pc_incr, pc_relbranch        sequencing requests from the decoder
//   branch_offset                signed offset relative to the branch PC
//   prog_addr / prog_data        ROM address out, read data in (1-cycle latency)
//   instr, instr_valid, pc       instruction, valid flag and its address
//   halted                       sticky halt after a self-branch
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int PSIZE = DEF_PSIZE,
   parameter int ISIZE = DEF_ISIZE
) (
   input  logic             clk,
   input  logic             n_reset,
   input  logic             run,
   input  logic             step,
   input  logic             pc_incr,
   input  logic             pc_relbranch,
   input  logic [PSIZE-1:0] branch_offset,
   output logic [PSIZE-1:0] prog_addr,
   input  logic [ISIZE-1:0] prog_data,
   output logic [ISIZE-1:0] instr,
   output logic             instr_valid,
   output logic [PSIZE-1:0] pc,
   output logic             halted
);

   localparam logic [PSIZE-1:0] ONE = PSIZE'(1);
   localparam logic [ISIZE-1:0] NOP = ISIZE'(NOP_WORD);

   logic [PSIZE-1:0] fpc_q, fpc_d;
   logic [PSIZE-1:0] pc_q, pc_d;
   state_t           state_q, state_d;
   logic             step_mode_q, step_mode_d;

   logic             br_taken;
   logic             seq_adv;
   logic             stop;

   // A taken branch overrides a simultaneous pc_incr; with neither
   // request the stage still falls through sequentially.
   assign br_taken = pc_relbranch;
   assign seq_adv  = pc_incr | ~pc_relbranch;
   assign stop     = step_mode_q | ~run;

   always_comb begin
      fpc_d       = fpc_q;
      pc_d        = pc_q;
      state_d     = state_q;
      step_mode_d = step_mode_q;
      instr       = NOP;
      instr_valid = 1'b0;
      halted      = 1'b0;

      unique case (state_q)
         IDLE: begin
            // run wins over step; step only arms single-step mode
            if (run || step) begin
               pc_d        = fpc_q;
               fpc_d       = fpc_q + ONE;
               step_mode_d = ~run;
               state_d     = EXEC;
            end
         end

         EXEC: begin
            instr       = prog_data;
            instr_valid = 1'b1;
            if (br_taken) begin
               if (branch_offset == '0) begin
                  fpc_d   = pc_q;
                  state_d = HALT;
               end else begin
                  // width-matched add == sign-extended add mod 2**PSIZE
                  fpc_d   = pc_q + branch_offset;
                  state_d = stop ? IDLE : FLUSH;
               end
            end else if (seq_adv) begin
               // fpc already points at pc_q+1
               if (stop) begin
                  state_d = IDLE;
               end else begin
                  pc_d  = fpc_q;
                  fpc_d = fpc_q + ONE;
               end
            end
         end

         FLUSH: begin
            // ROM still returns the stale fall-through word; drop it
            if (run) begin
               pc_d    = fpc_q;
               fpc_d   = fpc_q + ONE;
               state_d = EXEC;
            end else begin
               state_d = IDLE;
            end
         end

         HALT: begin
            halted = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         fpc_q       <= '0;
         pc_q        <= '0;
         state_q     <= IDLE;
         step_mode_q <= 1'b0;
      end else begin
         fpc_q       <= fpc_d;
         pc_q        <= pc_d;
         state_q     <= state_d;
         step_mode_q <= step_mode_d;
      end
   end

   assign prog_addr = fpc_q;
   assign pc        = pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit with a 1-cycle-latency ROM model.
// Bench plays the decoder role by driving pc_incr/pc_relbranch/offset.
module tb_fetch_unit;

   logic        clk;
   logic        n_reset;
   logic        run;
   logic        step;
   logic        pc_incr;
   logic        pc_relbranch;
   logic [5:0]  branch_offset;
   logic [5:0]  prog_addr;
   logic [23:0] prog_data;
   logic [23:0] instr;
   logic        instr_valid;
   logic [5:0]  pc;
   logic        halted;

   logic [23:0] rom [64];

   int ntests = 0;
   int nfail  = 0;

   fetch_unit #(.PSIZE(6), .ISIZE(24)) dut (
      .clk          (clk),
      .n_reset      (n_reset),
      .run          (run),
      .step         (step),
      .pc_incr      (pc_incr),
      .pc_relbranch (pc_relbranch),
      .branch_offset(branch_offset),
      .prog_addr    (prog_addr),
      .prog_data    (prog_data),
      .instr        (instr),
      .instr_valid  (instr_valid),
      .pc           (pc),
      .halted       (halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) prog_data <= rom[prog_addr];

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic reset_dut;
      n_reset       = 1'b0;
      run           = 1'b0;
      step          = 1'b0;
      pc_incr       = 1'b0;
      pc_relbranch  = 1'b0;
      branch_offset = 6'd0;
      tick();
      n_reset = 1'b1;
   endtask

   task automatic test_reset;
      n_reset       = 1'b0;
      run           = 1'b0;
      step          = 1'b0;
      pc_incr       = 1'b0;
      pc_relbranch  = 1'b0;
      branch_offset = 6'd0;
      #12;
      ntests++;
      if ({instr_valid, halted, instr, pc, prog_addr} !== 38'd0) begin
         nfail++;
         $display("FAIL reset: valid=%0b halted=%0b instr=%h pc=%0d addr=%0d, expected all 0",
                  instr_valid, halted, instr, pc, prog_addr);
      end
      tick();
      n_reset = 1'b1;
      tick();
      ntests++;
      if (instr_valid !== 1'b0 || prog_addr !== 6'd0) begin
         nfail++;
         $display("FAIL idle_hold: valid=%0b addr=%0d, expected valid=0 addr=0",
                  instr_valid, prog_addr);
      end
   endtask

   task automatic test_run_branch_halt;
      reset_dut();
      run     = 1'b1;
      pc_incr = 1'b1;
      ntests++;
      if (instr_valid !== 1'b0) begin
         nfail++;
         $display("FAIL first_cycle: valid=%0b, expected 0", instr_valid);
      end
      for (int k = 0; k < 6; k++) begin
         tick();
         ntests++;
         if (pc !== 6'(k) || instr_valid !== 1'b1 || instr !== rom[k]) begin
            nfail++;
            $display("FAIL seq k=%0d: pc=%0d valid=%0b instr=%h, expected pc=%0d valid=1 instr=%h",
                     k, pc, instr_valid, instr, k, rom[k]);
         end
      end
      pc_relbranch  = 1'b1;
      branch_offset = 6'h3D;
      tick();
      pc_relbranch = 1'b0;
      ntests++;
      if (instr_valid !== 1'b0 || instr !== 24'd0 || prog_addr !== 6'd2) begin
         nfail++;
         $display("FAIL flush_back: valid=%0b instr=%h addr=%0d, expected valid=0 instr=0 addr=2",
                  instr_valid, instr, prog_addr);
      end
      tick();
      ntests++;
      if (pc !== 6'd2 || instr_valid !== 1'b1 || instr !== rom[2]) begin
         nfail++;
         $display("FAIL target_back: pc=%0d valid=%0b instr=%h, expected pc=2 valid=1 instr=%h",
                  pc, instr_valid, instr, rom[2]);
      end
      tick();
      tick();
      ntests++;
      if (pc !== 6'd4 || instr_valid !== 1'b1) begin
         nfail++;
         $display("FAIL after_target: pc=%0d valid=%0b, expected pc=4 valid=1", pc, instr_valid);
      end
      pc_relbranch  = 1'b1;
      branch_offset = 6'd2;
      tick();
      pc_relbranch = 1'b0;
      ntests++;
      if (instr_valid !== 1'b0) begin
         nfail++;
         $display("FAIL flush_both: valid=%0b, expected 0", instr_valid);
      end
      tick();
      ntests++;
      if (pc !== 6'd6 || instr_valid !== 1'b1 || instr !== rom[6]) begin
         nfail++;
         $display("FAIL target_both: pc=%0d valid=%0b instr=%h, expected pc=6 valid=1 instr=%h",
                  pc, instr_valid, instr, rom[6]);
      end
      tick();
      pc_relbranch  = 1'b1;
      branch_offset = 6'd0;
      tick();
      pc_relbranch = 1'b0;
      ntests++;
      if (halted !== 1'b1 || instr_valid !== 1'b0 || instr !== 24'd0) begin
         nfail++;
         $display("FAIL halt_entry: halted=%0b valid=%0b instr=%h, expected halted=1 valid=0 instr=0",
                  halted, instr_valid, instr);
      end
      repeat (3) tick();
      ntests++;
      if (halted !== 1'b1 || pc !== 6'd7 || prog_addr !== 6'd7) begin
         nfail++;
         $display("FAIL halt_sticky: halted=%0b pc=%0d addr=%0d, expected halted=1 pc=7 addr=7",
                  halted, pc, prog_addr);
      end
      #2 n_reset = 1'b0;
      #1;
      ntests++;
      if (halted !== 1'b0 || pc !== 6'd0) begin
         nfail++;
         $display("FAIL halt_clear: halted=%0b pc=%0d, expected halted=0 pc=0", halted, pc);
      end
      tick();
      n_reset = 1'b1;
      run     = 1'b0;
   endtask

   task automatic test_flush_stop;
      reset_dut();
      run     = 1'b1;
      pc_incr = 1'b1;
      tick();
      tick();
      pc_relbranch  = 1'b1;
      branch_offset = 6'd3;
      tick();
      pc_relbranch = 1'b0;
      run          = 1'b0;
      tick();
      tick();
      ntests++;
      if (instr_valid !== 1'b0 || prog_addr !== 6'd4 || pc !== 6'd1) begin
         nfail++;
         $display("FAIL flush_stop: valid=%0b addr=%0d pc=%0d, expected valid=0 addr=4 pc=1",
                  instr_valid, prog_addr, pc);
      end
   endtask

   task automatic test_step_wrap;
      reset_dut();
      pc_incr = 1'b1;
      step    = 1'b1;
      tick();
      step = 1'b0;
      ntests++;
      if (pc !== 6'd0 || instr_valid !== 1'b1 || instr !== rom[0]) begin
         nfail++;
         $display("FAIL step0: pc=%0d valid=%0b instr=%h, expected pc=0 valid=1 instr=%h",
                  pc, instr_valid, instr, rom[0]);
      end
      tick();
      ntests++;
      if (instr_valid !== 1'b0 || prog_addr !== 6'd1) begin
         nfail++;
         $display("FAIL step0_idle: valid=%0b addr=%0d, expected valid=0 addr=1",
                  instr_valid, prog_addr);
      end
      step = 1'b1;
      tick();
      step          = 1'b0;
      pc_relbranch  = 1'b1;
      branch_offset = 6'h3E;
      tick();
      pc_relbranch = 1'b0;
      ntests++;
      if (instr_valid !== 1'b0 || prog_addr !== 6'd63) begin
         nfail++;
         $display("FAIL step_branch: valid=%0b addr=%0d, expected valid=0 addr=63",
                  instr_valid, prog_addr);
      end
      step = 1'b1;
      tick();
      step = 1'b0;
      ntests++;
      if (pc !== 6'd63 || instr_valid !== 1'b1 || instr !== rom[63]) begin
         nfail++;
         $display("FAIL step63: pc=%0d valid=%0b instr=%h, expected pc=63 valid=1 instr=%h",
                  pc, instr_valid, instr, rom[63]);
      end
      tick();
      ntests++;
      if (instr_valid !== 1'b0 || prog_addr !== 6'd0 || pc !== 6'd63) begin
         nfail++;
         $display("FAIL wrap: valid=%0b addr=%0d pc=%0d, expected valid=0 addr=0 pc=63",
                  instr_valid, prog_addr, pc);
      end
      step = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         ntests++;
         if (instr_valid !== ((k % 2) == 0) ||
             ((k % 2) == 0 && pc !== 6'(k / 2))) begin
            nfail++;
            $display("FAIL step_held k=%0d: valid=%0b pc=%0d, expected valid=%0b pc=%0d",
                     k, instr_valid, pc, ((k % 2) == 0), k / 2);
         end
      end
      step = 1'b0;
   endtask

   task automatic test_async_reset;
      reset_dut();
      run     = 1'b1;
      pc_incr = 1'b1;
      repeat (3) tick();
      ntests++;
      if (pc !== 6'd2 || instr_valid !== 1'b1) begin
         nfail++;
         $display("FAIL pre_reset: pc=%0d valid=%0b, expected pc=2 valid=1", pc, instr_valid);
      end
      #2 n_reset = 1'b0;
      #1;
      ntests++;
      if ({instr_valid, halted, instr, pc, prog_addr} !== 38'd0) begin
         nfail++;
         $display("FAIL async_reset: valid=%0b halted=%0b instr=%h pc=%0d addr=%0d, expected all 0",
                  instr_valid, halted, instr, pc, prog_addr);
      end
      tick();
      ntests++;
      if (instr_valid !== 1'b0 || pc !== 6'd0) begin
         nfail++;
         $display("FAIL reset_held: valid=%0b pc=%0d, expected valid=0 pc=0", instr_valid, pc);
      end
      n_reset = 1'b1;
      run     = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 64; i++)
         rom[i] = {6'(i + 1), 18'(i * 1021 + 5)};
      test_reset();
      test_run_branch_halt();
      test_flush_stop();
      test_step_wrap();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
